// File: rtl/io_writeback_arbiter_pkg.sv
// Shared types and helpers for the IO writeback arbiter and the command-side dispatcher.
package io_arb_pkg;

  localparam int DEF_DESTREGBITS  = 4;
  localparam int DEF_DATABITWIDTH = 16;

  typedef struct packed {
    logic                        reg_flag;
    logic                        mem_flag;
    logic [DEF_DESTREGBITS-1:0]  dest_reg;
    logic [DEF_DATABITWIDTH-1:0] data;
  } io_resp_t;

  // Port index reached by stepping 'step' places above 'last', wrapping at n.
  function automatic int next_rr_index(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/io_writeback_arbiter_if.sv
// Bundle of the per-module IOIn response channels and the CPU writeback channel.
interface io_writeback_arbiter_if #(
  parameter int NUMPORTS     = 4,
  parameter int DATABITWIDTH = 16,
  parameter int DESTREGBITS  = 4
);

  logic [NUMPORTS-1:0]              IOIn_REQ;
  logic [NUMPORTS-1:0]              IOIn_ACK;
  logic [NUMPORTS-1:0]              IOIn_RegResponseFlag;
  logic [NUMPORTS-1:0]              IOIn_MemResponseFlag;
  logic [NUMPORTS*DESTREGBITS-1:0]  IOIn_DestReg;
  logic [NUMPORTS*DATABITWIDTH-1:0] IOIn_Data;

  logic                    WritebackREQ;
  logic                    WritebackACK;
  logic                    WritebackRegFlag;
  logic                    WritebackMemFlag;
  logic [DESTREGBITS-1:0]  WritebackDestReg;
  logic [DATABITWIDTH-1:0] WritebackDataOut;

  // Arbiter side.
  modport slave (
    input  IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag, IOIn_DestReg, IOIn_Data,
    output IOIn_ACK,
    output WritebackREQ, WritebackRegFlag, WritebackMemFlag, WritebackDestReg, WritebackDataOut,
    input  WritebackACK
  );

  // IO modules plus CPU side.
  modport master (
    output IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag, IOIn_DestReg, IOIn_Data,
    input  IOIn_ACK,
    input  WritebackREQ, WritebackRegFlag, WritebackMemFlag, WritebackDestReg, WritebackDataOut,
    output WritebackACK
  );

endinterface

// File: rtl/io_writeback_arbiter_rr_grant_picker.sv
// Combinational round-robin picker: first eligible port strictly above last_grant, wrapping.
module rr_grant_picker
  import io_arb_pkg::*;
#(
  parameter int NUMPORTS = 4,
  parameter int IW       = 2
) (
  input  logic [NUMPORTS-1:0] eligible,
  input  logic [IW-1:0]       last_grant,
  output logic [NUMPORTS-1:0] grant,
  output logic [IW-1:0]       grant_index,
  output logic                any_grant
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest eligible one wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    any_grant   = 1'b0;
    cand        = '0;
    for (int k = NUMPORTS; k >= 1; k--) begin
      cand = IW'(next_rr_index(int'(last_grant), k, NUMPORTS));
      if (eligible[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_index = cand;
        any_grant   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_writeback_arbiter.sv
// Round-robin merge of NUMPORTS IO response channels into one registered CPU writeback stage.
module io_writeback_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUMPORTS     = 4,
  parameter int DATABITWIDTH = DEF_DATABITWIDTH,
  parameter int DESTREGBITS  = DEF_DESTREGBITS
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic [NUMPORTS-1:0]   PortEnable,
  io_writeback_arbiter_if.slave io,
  output logic                  DropPulse
);

  localparam int IW = $clog2(NUMPORTS);

  typedef struct packed {
    logic                    reg_flag;
    logic                    mem_flag;
    logic [DESTREGBITS-1:0]  dest_reg;
    logic [DATABITWIDTH-1:0] data;
  } resp_t;

  resp_t               port_resp [NUMPORTS];
  resp_t               sel_resp;
  logic [NUMPORTS-1:0] eligible;
  logic [NUMPORTS-1:0] grant;
  logic [IW-1:0]       grant_index;
  logic                any_grant;
  logic                accept;
  logic                has_resp;

  resp_t         resp_reg,       resp_next;
  logic          out_valid_reg,  out_valid_next;
  logic          drop_reg,       drop_next;
  logic [IW-1:0] last_grant_reg, last_grant_next;

  for (genvar gi = 0; gi < NUMPORTS; gi++) begin : g_unpack
    assign port_resp[gi] = {io.IOIn_RegResponseFlag[gi],
                            io.IOIn_MemResponseFlag[gi],
                            io.IOIn_DestReg[gi*DESTREGBITS +: DESTREGBITS],
                            io.IOIn_Data[gi*DATABITWIDTH +: DATABITWIDTH]};
  end

  assign eligible = io.IOIn_REQ & PortEnable;

  rr_grant_picker #(
    .NUMPORTS (NUMPORTS),
    .IW       (IW)
  ) u_picker (
    .eligible    (eligible),
    .last_grant  (last_grant_reg),
    .grant       (grant),
    .grant_index (grant_index),
    .any_grant   (any_grant)
  );

  // The stage can take a new entry when empty or when the CPU drains it this cycle.
  assign accept   = clk_en & (~out_valid_reg | io.WritebackACK);
  assign sel_resp = port_resp[grant_index];
  assign has_resp = sel_resp.reg_flag | sel_resp.mem_flag;

  // Gated by reset so no source sees an ACK while the block is held in reset.
  assign io.IOIn_ACK = (accept & async_rst_n) ? grant : '0;

  always_comb begin
    resp_next       = resp_reg;
    out_valid_next  = out_valid_reg;
    drop_next       = drop_reg;
    last_grant_next = last_grant_reg;
    if (accept) begin
      if (any_grant) begin
        last_grant_next = grant_index;
        if (has_resp) begin
          resp_next      = sel_resp;
          out_valid_next = 1'b1;
          drop_next      = 1'b0;
        end else begin
          // Posted write: consumed without occupying the writeback stage.
          out_valid_next = 1'b0;
          drop_next      = 1'b1;
        end
      end else begin
        out_valid_next = 1'b0;
        drop_next      = 1'b0;
      end
    end else if (clk_en) begin
      drop_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      resp_reg       <= '0;
      out_valid_reg  <= 1'b0;
      drop_reg       <= 1'b0;
      last_grant_reg <= IW'(NUMPORTS - 1);
    end else begin
      resp_reg       <= resp_next;
      out_valid_reg  <= out_valid_next;
      drop_reg       <= drop_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign io.WritebackREQ     = out_valid_reg;
  assign io.WritebackRegFlag = resp_reg.reg_flag;
  assign io.WritebackMemFlag = resp_reg.mem_flag;
  assign io.WritebackDestReg = resp_reg.dest_reg;
  assign io.WritebackDataOut = resp_reg.data;
  assign DropPulse           = drop_reg;

endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Directed bench for io_writeback_arbiter with a cycle-level behavioural model and literal checks.
module tb_io_writeback_arbiter;
  import io_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic [3:0] port_en;
  logic       drop;

  logic [3:0]  p_req, p_reg, p_mem;
  logic [3:0]  p_dest [4];
  logic [15:0] p_data [4];

  int n_cmp = 0;
  int n_bad = 0;

  io_writeback_arbiter_if #(.NUMPORTS(4), .DATABITWIDTH(16), .DESTREGBITS(4)) bus ();

  io_writeback_arbiter #(.NUMPORTS(4), .DATABITWIDTH(16), .DESTREGBITS(4)) dut (
    .clk         (clk),
    .async_rst_n (rst_n),
    .clk_en      (clk_en),
    .PortEnable  (port_en),
    .io          (bus),
    .DropPulse   (drop)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.IOIn_REQ             = p_req;
    bus.IOIn_RegResponseFlag = p_reg;
    bus.IOIn_MemResponseFlag = p_mem;
    for (int i = 0; i < 4; i++) begin
      bus.IOIn_DestReg[i*4 +: 4] = p_dest[i];
      bus.IOIn_Data[i*16 +: 16]  = p_data[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pick(input logic [3:0] e, input int last);
    for (int k = 1; k <= 4; k++)
      if (e[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  io_resp_t   m_resp;
  logic       m_valid, m_drop;
  int         m_last;
  int         m_g;
  logic       m_acc, m_has;
  logic [3:0] exp_ack;

  always_comb begin
    m_g     = pick(p_req & port_en, m_last);
    m_acc   = !m_valid || bus.WritebackACK;
    m_has   = (m_g >= 0) ? (p_reg[m_g] | p_mem[m_g]) : 1'b0;
    exp_ack = (rst_n && clk_en && m_acc && m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_drop  <= 1'b0;
      m_last  <= 3;
      m_resp  <= '0;
    end else if (clk_en) begin
      m_drop <= m_acc && (m_g >= 0) && !m_has;
      if (m_acc) m_valid <= (m_g >= 0) && m_has;
      if (m_acc && m_g >= 0) m_last <= m_g;
      if (m_acc && m_g >= 0 && m_has)
        m_resp <= '{reg_flag: p_reg[m_g], mem_flag: p_mem[m_g], dest_reg: p_dest[m_g], data: p_data[m_g]};
    end
  end

  always @(negedge clk) begin
    chk("model_ack", {28'd0, bus.IOIn_ACK}, {28'd0, exp_ack});
    chk("model_wbreq", {31'd0, bus.WritebackREQ}, {31'd0, m_valid});
    chk("model_drop", {31'd0, drop}, {31'd0, m_drop});
    if (m_valid) begin
      chk("model_regflag", {31'd0, bus.WritebackRegFlag}, {31'd0, m_resp.reg_flag});
      chk("model_memflag", {31'd0, bus.WritebackMemFlag}, {31'd0, m_resp.mem_flag});
      chk("model_dest", {28'd0, bus.WritebackDestReg}, {28'd0, m_resp.dest_reg});
      chk("model_data", {16'd0, bus.WritebackDataOut}, {16'd0, m_resp.data});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int i, input logic rf, input logic mf,
                      input logic [3:0] d, input logic [15:0] v);
    p_req[i]  = 1'b1;
    p_reg[i]  = rf;
    p_mem[i]  = mf;
    p_dest[i] = d;
    p_data[i] = v;
  endtask

  task automatic clr(input int i);
    p_req[i] = 1'b0;
  endtask

  int got_order [6];
  int exp_order [6];

  initial begin
    exp_order = '{0, 1, 2, 3, 0, 1};
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    port_en = 4'hF;
    p_req   = '0;
    p_reg   = '0;
    p_mem   = '0;
    for (int i = 0; i < 4; i++) begin
      p_dest[i] = '0;
      p_data[i] = '0;
    end
    bus.WritebackACK = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wbreq", {31'd0, bus.WritebackREQ}, 32'd0);
    chk("reset_data", {16'd0, bus.WritebackDataOut}, 32'd0);
    chk("reset_ack", {28'd0, bus.IOIn_ACK}, 32'd0);
    chk("reset_drop", {31'd0, drop}, 32'd0);
    cycle();
    rst_n = 1'b1;

    // Single request from port 2.
    setp(2, 1'b1, 1'b0, 4'd5, 16'hBEEF);
    bus.WritebackACK = 1'b1;
    @(negedge clk);
    chk("single_ack", {28'd0, bus.IOIn_ACK}, 32'h4);
    cycle();
    clr(2);
    @(negedge clk);
    chk("single_wbreq", {31'd0, bus.WritebackREQ}, 32'd1);
    chk("single_dest", {28'd0, bus.WritebackDestReg}, 32'd5);
    chk("single_data", {16'd0, bus.WritebackDataOut}, 32'hBEEF);
    chk("single_regflag", {31'd0, bus.WritebackRegFlag}, 32'd1);
    cycle();

    // Fairness from a fresh reset.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) setp(i, 1'b1, 1'b0, 4'(i), 16'h1000 + 16'(i));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got_order[c] = -1;
      for (int i = 0; i < 4; i++) if (bus.IOIn_ACK[i]) got_order[c] = i;
      if (c > 0) chk("fair_wbreq", {31'd0, bus.WritebackREQ}, 32'd1);
      cycle();
    end
    for (int c = 0; c < 6; c++) chk("fair_order", 32'(got_order[c]), 32'(exp_order[c]));
    p_req = '0;
    cycle();

    // Backpressure: port 1 held while port 3 waits.
    bus.WritebackACK = 1'b0;
    setp(1, 1'b1, 1'b0, 4'd1, 16'h1111);
    @(negedge clk);
    chk("bp_ack_p1", {28'd0, bus.IOIn_ACK}, 32'h2);
    cycle();
    clr(1);
    setp(3, 1'b0, 1'b1, 4'd3, 16'h3333);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ack_hold", {28'd0, bus.IOIn_ACK}, 32'd0);
      chk("bp_data_hold", {16'd0, bus.WritebackDataOut}, 32'h1111);
      cycle();
    end
    bus.WritebackACK = 1'b1;
    @(negedge clk);
    chk("bp_ack_p3", {28'd0, bus.IOIn_ACK}, 32'h8);
    cycle();
    clr(3);
    @(negedge clk);
    chk("bp_data_p3", {16'd0, bus.WritebackDataOut}, 32'h3333);
    chk("bp_memflag_p3", {31'd0, bus.WritebackMemFlag}, 32'd1);
    cycle();

    // Posted write on port 0, then port 1 gets the next grant.
    setp(0, 1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clk);
    chk("drop_ack", {28'd0, bus.IOIn_ACK}, 32'h1);
    cycle();
    clr(0);
    @(negedge clk);
    chk("drop_pulse", {31'd0, drop}, 32'd1);
    chk("drop_wbreq", {31'd0, bus.WritebackREQ}, 32'd0);
    cycle();
    setp(0, 1'b1, 1'b0, 4'd7, 16'hA0A0);
    setp(1, 1'b1, 1'b0, 4'd8, 16'hA1A1);
    @(negedge clk);
    chk("drop_next_grant", {28'd0, bus.IOIn_ACK}, 32'h2);
    cycle();
    clr(1);
    cycle();
    clr(0);
    cycle();

    // Mask: port 1 disabled and starved until re-enabled.
    port_en = 4'b1101;
    setp(1, 1'b1, 1'b0, 4'd9, 16'h0101);
    setp(2, 1'b1, 1'b0, 4'd10, 16'h0202);
    @(negedge clk);
    chk("mask_ack_p2", {28'd0, bus.IOIn_ACK}, 32'h4);
    cycle();
    clr(2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mask_starve", {28'd0, bus.IOIn_ACK}, 32'd0);
      cycle();
    end
    port_en = 4'hF;
    @(negedge clk);
    chk("mask_ack_p1", {28'd0, bus.IOIn_ACK}, 32'h2);
    cycle();
    clr(1);
    cycle();

    // Clock enable low blocks the handshake.
    clk_en = 1'b0;
    setp(3, 1'b1, 1'b0, 4'd11, 16'h0303);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("clken_ack", {28'd0, bus.IOIn_ACK}, 32'd0);
      cycle();
    end
    clk_en = 1'b1;
    @(negedge clk);
    chk("clken_resume", {28'd0, bus.IOIn_ACK}, 32'h8);
    cycle();
    clr(3);
    cycle();

    // Reset while an entry is held.
    bus.WritebackACK = 1'b0;
    setp(0, 1'b1, 1'b0, 4'd12, 16'h00AA);
    cycle();
    clr(0);
    setp(2, 1'b1, 1'b0, 4'd13, 16'h00BB);
    setp(3, 1'b1, 1'b0, 4'd14, 16'h00CC);
    @(negedge clk);
    chk("rst_hold_wbreq", {31'd0, bus.WritebackREQ}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_wbreq", {31'd0, bus.WritebackREQ}, 32'd0);
    chk("rst_async_ack", {28'd0, bus.IOIn_ACK}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    bus.WritebackACK = 1'b1;
    @(negedge clk);
    chk("rst_first_grant", {28'd0, bus.IOIn_ACK}, 32'h4);
    cycle();
    p_req = '0;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
